// File: rtl/panda_pkg.sv
// Shared types and constants for the panda execution datapath.
package panda_pkg;

    localparam int unsigned ShiftStepDefault = 4;

    typedef enum logic [1:0] {
        SHIFT_IDLE = 2'd0,
        SHIFT_BUSY = 2'd1,
        SHIFT_DONE = 2'd2
    } shifter_state_e;

endpackage

// File: rtl/panda_shifter.sv
// Single-cycle barrel shifter: left, logical right or arithmetic right by amount_i.
module panda_shifter #(
    parameter int unsigned Width = 32
) (
    input  logic [Width-1:0]         operand_i,
    input  logic [$clog2(Width)-1:0] amount_i,
    input  logic                     left_i,
    input  logic                     arithmetic_i,
    output logic [Width-1:0]         result_o
);

    // Arithmetic fill only applies to right shifts.
    always_comb begin
        result_o = operand_i;
        if (left_i) begin
            result_o = operand_i << amount_i;
        end else if (arithmetic_i) begin
            result_o = $signed(operand_i) >>> amount_i;
        end else begin
            result_o = operand_i >> amount_i;
        end
    end

endmodule

// File: rtl/panda_serial_shifter.sv
// Iterative shifter: shifts up to StepBits positions per cycle behind a
// valid/ready request and a separate valid/ready response handshake.
module panda_serial_shifter
    import panda_pkg::*;
#(
    parameter int unsigned Width    = 32,
    parameter int unsigned StepBits = ShiftStepDefault
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     req_valid_i,
    output logic                     req_ready_o,
    input  logic                     req_left_i,
    input  logic                     req_arithmetic_i,
    input  logic [Width-1:0]         req_operand_i,
    input  logic [$clog2(Width)-1:0] req_amount_i,
    output logic                     resp_valid_o,
    input  logic                     resp_ready_i,
    output logic [Width-1:0]         resp_result_o
);

    localparam int unsigned AmtW = $clog2(Width);
    localparam logic [AmtW:0] StepLimit = (AmtW + 1)'(StepBits);

    shifter_state_e   state_q, state_d;
    logic [Width-1:0] data_q, data_d;
    logic [Width-1:0] result_q, result_d;
    logic [AmtW-1:0]  rem_q, rem_d;
    logic             left_q, left_d;
    logic             arith_q, arith_d;
    logic             ready_q, valid_q;

    logic [AmtW-1:0]  step_c;
    logic             last_step_c;
    logic             accept_c;
    logic [Width-1:0] shifted_c;

    // StepLimit is one bit wider so StepBits == Width still compares correctly.
    assign step_c      = ({1'b0, rem_q} < StepLimit) ? rem_q : StepLimit[AmtW-1:0];
    assign last_step_c = ({1'b0, rem_q} <= StepLimit);
    assign accept_c    = req_valid_i && req_ready_o;

    assign req_ready_o   = ready_q && !flush_i;
    assign resp_valid_o  = valid_q;
    assign resp_result_o = result_q;

    panda_shifter #(
        .Width (Width)
    ) u_step (
        .operand_i    (data_q),
        .amount_i     (step_c),
        .left_i       (left_q),
        .arithmetic_i (arith_q),
        .result_o     (shifted_c)
    );

    // Next-state and datapath update.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        result_d = result_q;
        rem_d    = rem_q;
        left_d   = left_q;
        arith_d  = arith_q;

        case (state_q)
            SHIFT_IDLE: begin
                if (accept_c) begin
                    data_d  = req_operand_i;
                    left_d  = req_left_i;
                    arith_d = req_arithmetic_i;
                    rem_d   = req_amount_i;
                    if (req_amount_i == '0) begin
                        state_d  = SHIFT_DONE;
                        result_d = req_operand_i;
                    end else begin
                        state_d = SHIFT_BUSY;
                    end
                end
            end
            SHIFT_BUSY: begin
                data_d = shifted_c;
                rem_d  = rem_q - step_c;
                if (last_step_c) begin
                    state_d  = SHIFT_DONE;
                    result_d = shifted_c;
                end
            end
            SHIFT_DONE: begin
                if (resp_ready_i) begin
                    state_d = SHIFT_IDLE;
                end
            end
            default: state_d = SHIFT_IDLE;
        endcase

        // A flushed operation never publishes a result.
        if (flush_i) begin
            state_d  = SHIFT_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= SHIFT_IDLE;
            data_q   <= '0;
            result_q <= '0;
            rem_q    <= '0;
            left_q   <= 1'b0;
            arith_q  <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            result_q <= result_d;
            rem_q    <= rem_d;
            left_q   <= left_d;
            arith_q  <= arith_d;
            ready_q  <= (state_d == SHIFT_IDLE);
            valid_q  <= (state_d == SHIFT_DONE);
        end
    end

endmodule

// File: tb/tb_panda_serial_shifter.sv
// Scoreboard bench for panda_serial_shifter, one instance each for StepBits 1, 4 and 32.
module tb_panda_serial_shifter;

    typedef struct {
        logic [31:0] res;
        int          e;
        int          n;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors     = 0;
    int miscompares = 0;
    int done_cnt    = 0;

    logic [31:0] d_op  [6] = '{32'h0034543B, 32'hFFBD7FA6, 32'hFFBD7FA6,
                               32'hFFBD7FA6, 32'hFFBD7FA6, 32'h0034543B};
    logic [4:0]  d_amt [6] = '{5'd5, 5'd8, 5'd8, 5'd8, 5'd24, 5'd5};
    logic        d_l   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        d_a   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    function automatic void check(input string name, input int inst,
                                  input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s inst%0d t=%0t: got %h want %h", name, inst, $time, act, req);
        end
    endfunction

    // Shifts as multiply / floor-divide by a power of two.
    function automatic logic [31:0] model(input logic [31:0] op, input logic [4:0] amt,
                                          input logic l, input logic a);
        logic [63:0] pw;
        logic [63:0] p;
        pw = 64'd1 << amt;
        p  = 64'(op) * pw;
        if (l) return p[31:0];
        if (a && op[31]) return ~((~op) / pw[31:0]);
        return op / pw[31:0];
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int unsigned STEP = (g == 0) ? 1 : ((g == 1) ? 4 : 32);

        logic        rst, flush, req_valid, req_ready, left, arith;
        logic        resp_valid, resp_ready, fixed_ready, rnd_ready, rand_mode;
        logic [31:0] operand, result;
        logic [4:0]  amount;
        logic        prev_valid = 1'b0;
        exp_t        q[$];

        assign resp_ready = rand_mode ? rnd_ready : fixed_ready;

        always @(posedge clk) rnd_ready <= ($urandom_range(3) != 0);

        panda_serial_shifter #(
            .Width    (32),
            .StepBits (STEP)
        ) dut (
            .clk_i            (clk),
            .rst_i            (rst),
            .flush_i          (flush),
            .req_valid_i      (req_valid),
            .req_ready_o      (req_ready),
            .req_left_i       (left),
            .req_arithmetic_i (arith),
            .req_operand_i    (operand),
            .req_amount_i     (amount),
            .resp_valid_o     (resp_valid),
            .resp_ready_i     (resp_ready),
            .resp_result_o    (result)
        );

        // Monitor: compares every presented response against the scoreboard head.
        always @(negedge clk) begin
            if (rst) begin
                prev_valid = 1'b0;
            end else begin
                if (resp_valid) begin
                    if (q.size() == 0) begin
                        check("spurious_resp_valid", g, 32'(resp_valid), 32'd0);
                    end else begin
                        if (!prev_valid)
                            check("latency_cycle", g, 32'(cyc), 32'(q[0].e + q[0].n));
                        check(prev_valid ? "held_result" : "result", g, result, q[0].res);
                        if (resp_ready) void'(q.pop_front());
                    end
                end
                if (q.size() != 0)
                    check("ready_while_busy", g, 32'(req_ready), 32'd0);
                prev_valid = resp_valid && !resp_ready;
            end
        end

        // Called just after a rising edge; returns just after the acceptance edge.
        task automatic issue(input logic [31:0] op, input logic [4:0] amt,
                             input logic l, input logic a);
            bit acc;
            acc       = 1'b0;
            operand   = op;
            amount    = amt;
            left      = l;
            arith     = a;
            req_valid = 1'b1;
            for (int i = 0; i < 300 && !acc; i++) begin
                @(negedge clk);
                acc = req_ready;
                @(posedge clk);
                #1;
            end
            req_valid = 1'b0;
            if (acc) begin
                q.push_back('{model(op, amt, l, a), cyc, (int'(amt) + STEP - 1) / STEP});
            end else begin
                check("accept_timeout", g, 32'(acc), 32'd1);
            end
            operand = $urandom;
            amount  = 5'($urandom);
            left    = 1'($urandom);
            arith   = 1'($urandom);
        endtask

        task automatic wait_idle();
            bit idle;
            idle = 1'b0;
            for (int i = 0; i < 400 && !idle; i++) begin
                @(negedge clk);
                idle = (q.size() == 0) && !resp_valid;
            end
            if (!idle) check("drain_timeout", g, 32'(idle), 32'd1);
            @(posedge clk);
            #1;
        endtask

        initial begin
            rst         = 1'b1;
            flush       = 1'b0;
            req_valid   = 1'b0;
            left        = 1'b0;
            arith       = 1'b0;
            operand     = '0;
            amount      = '0;
            fixed_ready = 1'b1;
            rand_mode   = 1'b0;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            check("reset_req_ready", g, 32'(req_ready), 32'd1);
            check("reset_resp_valid", g, 32'(resp_valid), 32'd0);
            check("reset_result", g, result, 32'd0);
            @(posedge clk);
            #1;

            for (int i = 0; i < 6; i++) begin
                issue(d_op[i], d_amt[i], d_l[i], d_a[i]);
                wait_idle();
            end

            // Zero amount held under back-pressure.
            fixed_ready = 1'b0;
            issue(32'h12345678, 5'd0, 1'b0, 1'b0);
            repeat (5) begin
                @(posedge clk);
                #1;
            end
            fixed_ready = 1'b1;
            wait_idle();

            // Flush mid-operation, with a request offered during the flush.
            fixed_ready = 1'b0;
            issue(32'hA5C3F00F, 5'd20, 1'b0, 1'b1);
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            flush     = 1'b1;
            operand   = 32'hDEADBEEF;
            amount    = 5'd3;
            req_valid = 1'b1;
            @(posedge clk);
            #1;
            q.delete();
            @(negedge clk);
            check("flush_gates_ready", g, 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
            flush       = 1'b0;
            req_valid   = 1'b0;
            fixed_ready = 1'b1;
            @(negedge clk);
            check("ready_after_flush", g, 32'(req_ready), 32'd1);
            @(posedge clk);
            #1;
            issue(32'h80000001, 5'd1, 1'b0, 1'b1);
            wait_idle();

            // Reset mid-operation.
            fixed_ready = 1'b0;
            issue(32'h0F0F1234, 5'd20, 1'b1, 1'b0);
            repeat (2) begin
                @(posedge clk);
                #1;
            end
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            q.delete();
            fixed_ready = 1'b1;
            @(negedge clk);
            check("result_after_reset", g, result, 32'd0);
            check("ready_after_reset", g, 32'(req_ready), 32'd1);
            check("valid_after_reset", g, 32'(resp_valid), 32'd0);
            @(posedge clk);
            #1;
            issue(32'h0F0F1234, 5'd1, 1'b1, 1'b0);
            wait_idle();

            rand_mode = 1'b1;
            for (int i = 0; i < 1000; i++) begin
                issue($urandom, 5'($urandom_range(31)), 1'($urandom), 1'($urandom));
            end
            wait_idle();
            rand_mode = 1'b0;
            done_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && done_cnt < 3; i++) @(posedge clk);
        if (done_cnt < 3) begin
            miscompares++;
            $display("FAIL run_timeout: %0d of 3 instances finished", done_cnt);
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/panda_serial_shifter.md
Name: panda_serial_shifter

Overview:
Multi-cycle iterative shifter: the area-lean counterpart to the single-cycle panda_shifter. It is a responder on a valid/ready request/response interface, driven by the ALU or the M/Zb sequencer. It accepts one shift operation at a time and shifts StepBits positions per cycle. It returns the result on a separate response handshake.

Parameters:
Width, 32, operand/result width; power of two, >= 8.
StepBits, 4, maximum shift per cycle; power of two, 1..Width.

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, synchronous, active-high; one clock, sampled on clk_i rising edge
flush_i  input  1  abort any in-flight operation
req_valid_i  input  1  request valid
req_ready_o  output  1  request ready
req_left_i  input  1  1 = shift left, 0 = shift right
req_arithmetic_i  input  1  sign-fill on right shift; ignored when left
req_operand_i  input  Width  value to shift
req_amount_i  input  $clog2(Width)  shift amount, 0..Width-1
resp_valid_o  output  1  result valid
resp_ready_i  input  1  consumer ready
resp_result_o  output  Width  shifted result

Behaviour:
- States: IDLE, SHIFT, DONE. Reset and flush go to IDLE.
- Reset values: req_ready_o=1, resp_valid_o=0, resp_result_o=0, remaining=0.
- Output decode: req_ready_o=1 only in IDLE. resp_valid_o=1 only in DONE.
- Acceptance: req_valid_i && req_ready_o on edge E. At E, latch operand into the data register and latch left, arithmetic and remaining=amount.
  - amount==0: IDLE->DONE at E; result = operand unchanged.
  - amount>0: IDLE->SHIFT at E.
- SHIFT, each cycle:
  - step = min(StepBits, remaining).
  - data <= data shifted by step, with zero fill for left or logical right and data MSB fill for arithmetic right.
  - remaining <= remaining - step.
  - If remaining <= StepBits, transition to DONE on that edge.
- Latency: resp_valid_o is first high in the cycle after edge E+N, where N = ceil(amount/StepBits). N=0 for amount 0.
- DONE: resp_result_o holds data stable while resp_valid_o=1 && !resp_ready_i.
  - On resp_valid_o && resp_ready_i, go DONE->IDLE.
  - No request is accepted in the same cycle as the response handshake. Minimum issue interval is N+2 cycles.
- resp_result_o holds its last value in IDLE and SHIFT.
- flush_i, any state: go to IDLE next edge and drop the in-flight operation; no response is produced.
  - A request presented with flush_i=1 is not accepted (req_ready_o is gated by !flush_i).
  - rst_i has priority over flush_i.
- Arithmetic flag with left=1: no effect, zero fill.
- Arithmetic right of a negative operand with large amounts saturates to all ones. Logical right saturates to 0.
- Request inputs are sampled only at acceptance. Later changes do not affect the in-flight operation.
- Reset mid-operation: same as flush, and resp_result_o returns to 0.

Decomposition:
- panda_pkg gains the enum type shifter_state_e {SHIFT_IDLE, SHIFT_BUSY, SHIFT_DONE}.
- panda_pkg also gains the constant ShiftStepDefault = 4.
- Natural sub-module: instantiate existing panda_shifter (Width) as the per-cycle shift datapath.
  - amount_i = step, left_i and arithmetic_i from the latched flags, operand_i = data register.
- The FSM, remaining counter and handshake logic stay in panda_serial_shifter.

Test Plan:
- Right logical, StepBits=4: operand 0x0034543B, amount 5, left 0, arith 0. Result 0x0001A2A1; resp_valid_o rises 2 cycles after acceptance.
- Arithmetic right and left shift of the same operand: operand 0xFFBD7FA6, amount 8.
  - arith 1 -> 0xFFFFBD7F.
  - arith 0 -> 0x00FFBD7F.
  - left 1 -> 0xBD7FA600.
  - Each with N=2.
- Long left and left with arithmetic set:
  - operand 0xFFBD7FA6, amount 24, left 1 -> 0xA6000000, N=6.
  - operand 0x0034543B, amount 5, left 1, arith 1 -> 0x068A8760 (arith ignored).
- Zero amount and back-pressure: amount 0, operand 0x12345678 -> result 0x12345678 in the cycle after acceptance.
  - Hold resp_ready_i=0 for 5 cycles: resp_valid_o and the result stay stable and req_ready_o stays 0.
- Flush and reset mid-operation, StepBits=1: amount 20, flush_i pulsed at cycle 3.
  - No resp_valid_o; req_ready_o=1 the next cycle; a following amount 1 request completes correctly.
  - Repeat with rst_i: resp_result_o reads 0.
- Random stress: 1000 random operand/amount/left/arith with random resp_ready_i stalls, checked against a reference model.
  - Checks: result, exact latency N, and no acceptance while busy.
  - Run with StepBits 1, 4 and 32.
